rf_xfer_engine: RTL and testbench

//  Command-driven data-transfer initiator for the 32x8 dual-read/single-write file register.

---
 rtl/rf_xfer_pkg.sv | 25 ++
 rtl/rf_xfer_addr_gen.sv | 53 +++++
 rtl/rf_xfer_engine.sv | 190 +++++++++++++++++++
 tb/tb_rf_xfer_engine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_xfer_pkg.sv
// Shared types and default sizes for the register-file transfer engine.
package rf_xfer_pkg;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 2 ** AW;
  localparam int unsigned LEN_W = AW + 1;

  typedef enum logic [1:0] {
    OpMove = 2'd0,
    OpFill = 2'd1,
    OpSwap = 2'd2,
    OpRsvd = 2'd3
  } xfer_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StMove,
    StFill,
    StSwapRd,
    StSwapWr,
    StDone
  } xfer_state_e;

endpackage

// File: rtl/rf_xfer_addr_gen.sv
// Loadable address pointer with up/down stepping and a remaining-element count.
module rf_xfer_addr_gen
  import rf_xfer_pkg::*;
#(
  parameter int unsigned AW = rf_xfer_pkg::AW,
  parameter int unsigned LW = rf_xfer_pkg::LEN_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  input  logic          down,
  input  logic          step,
  output logic [AW-1:0] ptr,
  output logic          last
);

  logic [AW-1:0] ptr_q, ptr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          down_q, down_d;

  always_comb begin
    ptr_d  = ptr_q;
    rem_d  = rem_q;
    down_d = down_q;
    if (load) begin
      down_d = down;
      rem_d  = len;
      // Descending walks start at the last element; truncating len is exact mod 2**AW.
      ptr_d  = down ? base + AW'(len) - AW'(1) : base;
    end else if (step) begin
      ptr_d = down_q ? ptr_q - AW'(1) : ptr_q + AW'(1);
      rem_d = rem_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      rem_q  <= '0;
      down_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      rem_q  <= rem_d;
      down_q <= down_d;
    end
  end

  assign ptr  = ptr_q;
  assign last = (rem_q == LW'(1));

endmodule

// File: rtl/rf_xfer_engine.sv
// Block MOVE/FILL/SWAP initiator for the dual-read/single-write file register.
// Define XFER_CHKSUM_EN to build the mod-256 written-data checksum on chk_sum.
module rf_xfer_engine
  import rf_xfer_pkg::*;
#(
  parameter int unsigned AW = rf_xfer_pkg::AW,
  parameter int unsigned DW = rf_xfer_pkg::DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_src,
  input  logic [AW-1:0] cmd_dst,
  input  logic [AW:0]   cmd_len,
  input  logic [DW-1:0] cmd_fill,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          FR_WE,
  output logic [AW-1:0] FR_Waddr,
  output logic [DW-1:0] FR_Wdata,
  output logic [AW-1:0] FR_RAddr_1,
  input  logic [DW-1:0] FR_Rdata_1,
  output logic [AW-1:0] FR_RAddr_2,
  input  logic [DW-1:0] FR_Rdata_2,
  output logic [DW-1:0] chk_sum
);

  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] Limit = LW'(1) << AW;

  xfer_state_e   state_q, state_d;
  logic          err_q, err_d;
  logic [DW-1:0] fill_q, tmp_q;
  logic [AW-1:0] src_ptr, dst_ptr;
  logic          src_last, dst_last, step_src, step_dst;
  logic          accept, reject, descend, overlap;
  logic [LW-1:0] src_end, dst_end;
  xfer_op_e      op;

  assign op      = xfer_op_e'(cmd_op);
  assign accept  = cmd_valid & cmd_ready;
  assign src_end = LW'(cmd_src) + cmd_len;
  assign dst_end = LW'(cmd_dst) + cmd_len;
  assign overlap = (cmd_len != '0) && (LW'(cmd_src) < dst_end) && (LW'(cmd_dst) < src_end);
  assign reject  = (op == OpRsvd) || (src_end > Limit) || (dst_end > Limit) ||
                   ((op == OpSwap) && overlap);
  // A forward copy into the tail of its own source would read already-written data.
  assign descend = (op == OpMove) && (cmd_dst > cmd_src) && (LW'(cmd_dst) < src_end);

  rf_xfer_addr_gen #(.AW(AW), .LW(LW)) u_src_gen (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .base (cmd_src),
    .len  (cmd_len),
    .down (descend),
    .step (step_src),
    .ptr  (src_ptr),
    .last (src_last)
  );

  rf_xfer_addr_gen #(.AW(AW), .LW(LW)) u_dst_gen (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .base (cmd_dst),
    .len  (cmd_len),
    .down (descend),
    .step (step_dst),
    .ptr  (dst_ptr),
    .last (dst_last)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    step_src = 1'b0;
    step_dst = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          err_d = reject;
          if (reject || (cmd_len == '0)) begin
            state_d = StDone;
          end else begin
            unique case (op)
              OpMove:  state_d = StMove;
              OpFill:  state_d = StFill;
              default: state_d = StSwapRd;
            endcase
          end
        end
      end
      StMove: begin
        step_src = 1'b1;
        step_dst = 1'b1;
        if (src_last) state_d = StDone;
      end
      StFill: begin
        step_dst = 1'b1;
        if (dst_last) state_d = StDone;
      end
      StSwapRd: state_d = StSwapWr;
      StSwapWr: begin
        step_src = 1'b1;
        step_dst = 1'b1;
        state_d  = src_last ? StDone : StSwapRd;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    FR_WE      = 1'b0;
    FR_Waddr   = '0;
    FR_Wdata   = '0;
    FR_RAddr_1 = '0;
    FR_RAddr_2 = '0;
    unique case (state_q)
      StMove: begin
        FR_WE      = 1'b1;
        FR_Waddr   = dst_ptr;
        FR_Wdata   = FR_Rdata_1;
        FR_RAddr_1 = src_ptr;
      end
      StFill: begin
        FR_WE    = 1'b1;
        FR_Waddr = dst_ptr;
        FR_Wdata = fill_q;
      end
      StSwapRd: begin
        FR_WE      = 1'b1;
        FR_Waddr   = dst_ptr;
        FR_Wdata   = FR_Rdata_1;
        FR_RAddr_1 = src_ptr;
        FR_RAddr_2 = dst_ptr;
      end
      StSwapWr: begin
        FR_WE      = 1'b1;
        FR_Waddr   = src_ptr;
        FR_Wdata   = tmp_q;
        FR_RAddr_1 = src_ptr;
        FR_RAddr_2 = dst_ptr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      fill_q  <= '0;
      tmp_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (accept) fill_q <= cmd_fill;
      if (state_q == StSwapRd) tmp_q <= FR_Rdata_2;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = done & err_q;

`ifdef XFER_CHKSUM_EN
  logic [DW-1:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else if (accept) begin
      sum_q <= '0;
    end else if (FR_WE) begin
      sum_q <= sum_q + FR_Wdata;
    end
  end

  assign chk_sum = sum_q;
`else
  assign chk_sum = '0;
`endif

endmodule

// File: tb/tb_rf_xfer_engine.sv
// Directed bench for rf_xfer_engine with a 32x8 file register model (reg[i]=i at init).
module tb_rf_xfer_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_src, cmd_dst;
  logic [5:0] cmd_len;
  logic [7:0] cmd_fill;
  logic       busy, done, err;
  logic       FR_WE;
  logic [4:0] FR_Waddr, FR_RAddr_1, FR_RAddr_2;
  logic [7:0] FR_Wdata, FR_Rdata_1, FR_Rdata_2, chk_sum;

  int checks = 0;
  int passed = 0;

  logic [7:0] mem [32];
  logic       mem_init;

  logic [4:0] wa [64];
  logic [7:0] wd [64];
  int         nwr, done_at;
  logic       done_seen, done_err, first_we, ctl_ok;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i);
    end else if (FR_WE) begin
      mem[FR_Waddr] <= FR_Wdata;
    end
  end

  assign FR_Rdata_1 = mem[FR_RAddr_1];
  assign FR_Rdata_2 = mem[FR_RAddr_2];

  rf_xfer_engine dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_len    (cmd_len),
    .cmd_fill   (cmd_fill),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .FR_WE      (FR_WE),
    .FR_Waddr   (FR_Waddr),
    .FR_Wdata   (FR_Wdata),
    .FR_RAddr_1 (FR_RAddr_1),
    .FR_Rdata_1 (FR_Rdata_1),
    .FR_RAddr_2 (FR_RAddr_2),
    .FR_Rdata_2 (FR_Rdata_2),
    .chk_sum    (chk_sum)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Issue one command and log every write until done (bounded to 100 cycles).
  task automatic run_cmd(input logic [1:0] op, input int src, input int dst, input int len,
                         input logic [7:0] fill);
    check("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
    cmd_op    = op;
    cmd_src   = 5'(src);
    cmd_dst   = 5'(dst);
    cmd_len   = 6'(len);
    cmd_fill  = fill;
    cmd_valid = 1'b1;
    tick();
    // Scramble the fields: the engine must work from its latched copy.
    cmd_valid = 1'b0;
    cmd_op    = 2'd3;
    cmd_src   = ~cmd_src;
    cmd_dst   = ~cmd_dst;
    cmd_len   = 6'd33;
    cmd_fill  = ~cmd_fill;
    nwr       = 0;
    done_seen = 1'b0;
    done_err  = 1'b0;
    done_at   = -1;
    first_we  = FR_WE;
    ctl_ok    = 1'b1;
    for (int c = 0; c < 100 && !done_seen; c++) begin
      if (busy !== 1'b1 || cmd_ready !== 1'b0) ctl_ok = 1'b0;
      if (err && !done) ctl_ok = 1'b0;
      if (FR_WE && done) ctl_ok = 1'b0;
      if (FR_WE === 1'b1 && nwr < 64) begin
        wa[nwr] = FR_Waddr;
        wd[nwr] = FR_Wdata;
        nwr++;
      end
      if (done === 1'b1) begin
        done_seen = 1'b1;
        done_at   = c;
        done_err  = err;
      end else begin
        tick();
      end
    end
    check("done_seen", {31'd0, done_seen}, 32'd1);
    check("busy_ready_while_active", {31'd0, ctl_ok}, 32'd1);
    tick();
  endtask

  initial begin
    logic saw_done;
    rst       = 1'b1;
    mem_init  = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_src   = '0;
    cmd_dst   = '0;
    cmd_len   = '0;
    cmd_fill  = '0;
    tick();
    tick();
    check("rst_busy_done_err_we", {28'd0, busy, done, err, FR_WE}, 32'd0);
    check("rst_waddr_wdata", {19'd0, FR_Waddr, FR_Wdata}, 32'd0);
    check("rst_raddrs", {22'd0, FR_RAddr_1, FR_RAddr_2}, 32'd0);
    check("rst_chk_sum", {24'd0, chk_sum}, 32'd0);
    rst      = 1'b0;
    mem_init = 1'b0;
    tick();
    check("ready_after_rst", {31'd0, cmd_ready}, 32'd1);

    // MOVE 0 -> 16, len 4
    run_cmd(2'd0, 0, 16, 4, 8'h00);
    check("mv_first_we", {31'd0, first_we}, 32'd1);
    check("mv_nwr", nwr, 4);
    check("mv_done_at", done_at, 4);
    check("mv_err", {31'd0, done_err}, 32'd0);
    check("mv_w0", {wa[0], wd[0]}, {5'd16, 8'd0});
    check("mv_w1", {wa[1], wd[1]}, {5'd17, 8'd1});
    check("mv_w2", {wa[2], wd[2]}, {5'd18, 8'd2});
    check("mv_w3", {wa[3], wd[3]}, {5'd19, 8'd3});
`ifdef XFER_CHKSUM_EN
    check("mv_chk_sum", {24'd0, chk_sum}, 32'h06);
`else
    check("mv_chk_sum_off", {24'd0, chk_sum}, 32'h00);
`endif

    // Overlapping MOVE 2 -> 4, len 4: must go descending
    run_cmd(2'd0, 2, 4, 4, 8'h00);
    check("ov_nwr", nwr, 4);
    check("ov_w0", {wa[0], wd[0]}, {5'd7, 8'd5});
    check("ov_w1", {wa[1], wd[1]}, {5'd6, 8'd4});
    check("ov_w3", {wa[3], wd[3]}, {5'd4, 8'd2});
    check("ov_mem4_7", {mem[4], mem[5], mem[6], mem[7]}, 32'h02030405);

    // FILL 30..31 with A5, then an out-of-range FILL
    run_cmd(2'd1, 0, 30, 2, 8'hA5);
    check("fill_nwr", nwr, 2);
    check("fill_err", {31'd0, done_err}, 32'd0);
    check("fill_mem", {16'd0, mem[30], mem[31]}, 32'hA5A5);
    run_cmd(2'd1, 0, 31, 2, 8'h5A);
    check("fill_oob_err", {31'd0, done_err}, 32'd1);
    check("fill_oob_nwr", nwr, 0);
    check("fill_oob_done_at", done_at, 0);
    check("fill_oob_mem31", {24'd0, mem[31]}, 32'hA5);

    // SWAP [1,2] <-> [10,11], then an overlapping SWAP
    run_cmd(2'd2, 1, 10, 2, 8'h00);
    check("sw_nwr", nwr, 4);
    check("sw_done_at", done_at, 4);
    check("sw_w0", {wa[0], wd[0]}, {5'd10, 8'd1});
    check("sw_w1", {wa[1], wd[1]}, {5'd1, 8'd10});
    check("sw_mem", {mem[1], mem[2], mem[10], mem[11]}, 32'h0A0B0102);
    run_cmd(2'd2, 1, 2, 2, 8'h00);
    check("sw_ovl_err", {31'd0, done_err}, 32'd1);
    check("sw_ovl_nwr", nwr, 0);

    // Reserved op, then zero-length MOVE
    run_cmd(2'd3, 0, 8, 1, 8'h00);
    check("rsvd_err", {31'd0, done_err}, 32'd1);
    check("rsvd_nwr", nwr, 0);
    run_cmd(2'd0, 0, 8, 0, 8'h00);
    check("len0_err", {31'd0, done_err}, 32'd0);
    check("len0_nwr", nwr, 0);
    check("len0_done_at", done_at, 0);

    // Reset in the third write cycle of MOVE 0 -> 16, len 8
    mem_init = 1'b1;
    tick();
    mem_init  = 1'b0;
    cmd_op    = 2'd0;
    cmd_src   = 5'd0;
    cmd_dst   = 5'd16;
    cmd_len   = 6'd8;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("rmid_we_c1", {31'd0, FR_WE}, 32'd1);
    tick();
    tick();
    check("rmid_addr_c3", {27'd0, FR_Waddr}, 32'd18);
    rst = 1'b1;
    #1;
    check("rmid_we_drop", {30'd0, FR_WE, busy}, 32'd0);
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (done) saw_done = 1'b1;
      tick();
    end
    check("rmid_no_done", {31'd0, saw_done}, 32'd0);
    check("rmid_ready", {31'd0, cmd_ready}, 32'd1);
    check("rmid_mem16_19", {mem[16], mem[17], mem[18], mem[19]}, 32'h00011213);
    check("rmid_mem23", {24'd0, mem[23]}, 32'd23);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
